// File: rtl/hps_spi_master_if.sv
// Command/response bus of the HPS-side SPI initiator.
// The bench drives it through the master modport, and the initiator serves it through the slave modport.
interface hps_spi_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_status;
  logic [63:0] rsp_data;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_status, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_status, rsp_data, busy
  );
endinterface

// File: rtl/hps_spi_master.sv
// Mode-0 SPI initiator: sends an opcode byte plus 0-8 payload bytes and captures the bytes the slave
// returns. The SPI pins are decoded from registered state, so each one changes only just after a clock edge.
module hps_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic             CLK_50M,
  input  logic             RESET,
  hps_spi_master_if.slave  bus,
  output logic             SPI_SCK,
  output logic             SPI_SS3,
  output logic             SPI_DI,
  input  logic             SPI_DO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        high_q, high_d;
  logic [6:0]  bit_q, bit_d;
  logic [6:0]  nbits_q, nbits_d;
  logic [71:0] tx_q, tx_d;
  logic [7:0]  status_q, status_d;
  logic [63:0] data_q, data_d;
  logic        vld_q, vld_d;

  logic        div_done;
  logic        last_bit;
  logic        smp;
  logic [6:0]  smp_bit;
  logic [2:0]  smp_byte;
  logic [5:0]  rx_idx;

  // Lengths above 8 are treated as 8; the result is the total bit count including the opcode byte.
  function automatic logic [6:0] bit_count(input logic [3:0] len);
    logic [3:0] l;
    logic [3:0] nb;
    l  = (len > 4'd8) ? 4'd8 : len;
    nb = l + 4'd1;
    return {nb, 3'b000};
  endfunction

  // The transmit word starts with the opcode, followed by payload byte 0, then byte 1, and so on.
  function automatic logic [71:0] pack_tx(input logic [7:0] op, input logic [63:0] data);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[63-8*i -: 8] = data[8*i +: 8];
    end
    return {op, r};
  endfunction

  assign div_done = (div_q == 8'd0);
  assign last_bit = (bit_q == (nbits_q - 7'd1));

  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      state_q  <= IDLE;
      div_q    <= 8'd0;
      high_q   <= 1'b0;
      bit_q    <= 7'd0;
      nbits_q  <= 7'd0;
      tx_q     <= 72'd0;
      status_q <= 8'd0;
      data_q   <= 64'd0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      high_q   <= high_d;
      bit_q    <= bit_d;
      nbits_q  <= nbits_d;
      tx_q     <= tx_d;
      status_q <= status_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    high_d   = high_q;
    bit_d    = bit_q;
    nbits_d  = nbits_q;
    tx_d     = tx_q;
    status_d = status_q;
    data_d   = data_q;
    vld_d    = 1'b0;
    smp      = 1'b0;
    smp_bit  = 7'd0;
    smp_byte = 3'd0;
    rx_idx   = 6'd0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d  = SETUP;
          div_d    = DIV_RELOAD;
          high_d   = 1'b0;
          bit_d    = 7'd0;
          nbits_d  = bit_count(bus.cmd_len);
          tx_d     = pack_tx(bus.cmd_op, bus.cmd_data);
          status_d = 8'd0;
          data_d   = 64'd0;
        end
      end
      SETUP: begin
        if (div_done) begin
          state_d = SHIFT;
          high_d  = 1'b1;
          div_d   = DIV_RELOAD;
          smp     = 1'b1;
          smp_bit = 7'd0;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      SHIFT: begin
        if (!div_done) begin
          div_d = div_q - 8'd1;
        end else begin
          div_d = DIV_RELOAD;
          if (high_q) begin
            high_d = 1'b0;
            // During the low phase of the final bit (the hold time), DI keeps that bit's value.
            if (!last_bit) tx_d = {tx_q[70:0], 1'b0};
          end else if (last_bit) begin
            state_d = GAP;
          end else begin
            high_d  = 1'b1;
            bit_d   = bit_q + 7'd1;
            smp     = 1'b1;
            smp_bit = bit_q + 7'd1;
          end
        end
      end
      GAP: begin
        if (div_done) begin
          state_d = IDLE;
          vld_d   = 1'b1;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Each received bit goes straight into its final byte/bit position, so no realignment is needed at the end.
    if (smp) begin
      smp_byte = smp_bit[5:3] - 3'd1;
      rx_idx   = {smp_byte, ~smp_bit[2:0]};
      if (smp_bit[6:3] == 4'd0) status_d[~smp_bit[2:0]] = SPI_DO;
      else                      data_d[rx_idx]          = SPI_DO;
    end
  end

  always_comb begin
    SPI_SS3 = 1'b1;
    SPI_SCK = 1'b0;
    SPI_DI  = 1'b0;
    if (state_q == SETUP || state_q == SHIFT) begin
      SPI_SS3 = 1'b0;
      SPI_SCK = (state_q == SHIFT) && high_q;
      SPI_DI  = tx_q[71];
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.rsp_valid  = vld_q;
  assign bus.rsp_status = status_q;
  assign bus.rsp_data   = data_q;

endmodule

// File: doc/hps_spi_master.md
# hps_spi_master

Host-side SPI initiator for the user I/O command bus: drives SPI_SCK, SPI_SS3 and SPI_DI, and samples SPI_DO, exactly as the HPS does toward the core's user I/O slave. It serialises one command per transaction, an opcode byte followed by 0–8 payload bytes, and captures the bytes the slave returns. It is the stimulus engine for core-level benches and for loopback self-test builds, and sits directly on the USER_IN/USER_OUT SPI pins.

## Interface
- CLK_DIV, 4: SCK half-period in CLK_50M cycles; legal range 1–255.
- CLK_50M  in  1  system clock; all logic rises on it.
- RESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command transfers on `cmd_valid && cmd_ready`.
- cmd_op  in  8  opcode byte; sent first.
- cmd_len  in  4  payload byte count; values above 8 saturate to 8.
- cmd_data  in  64  payload; byte i is `[8i+7:8i]` and is sent i-th.
- rsp_valid  out  1  one-cycle pulse when a transaction completes.
- rsp_status  out  8  byte shifted in while the opcode was sent.
- rsp_data  out  64  byte i is the byte received during payload byte i; unused bytes are 0.
- busy  out  1  high whenever not in IDLE.
- SPI_SCK  out  1  serial clock, mode 0 (idle low).
- SPI_SS3  out  1  slave select, active low.
- SPI_DI  out  1  master-out data to the slave.
- SPI_DO  in  1  slave-out data.

## Operation
- FSM states: IDLE → SETUP → SHIFT → GAP → IDLE.
- **IDLE**
  - Outputs: SPI_SS3=1, SPI_SCK=0, SPI_DI=0, cmd_ready=1.
  - On accept, latch cmd_op, cmd_data, and the saturated length into N = 8·(1+len) bits.
  - Clear rsp_data and rsp_status.
- **SETUP** (CLK_DIV cycles)
  - SS3=0, SCK=0.
  - SPI_DI = cmd_op[7].
- **SHIFT** (N bits; each bit is CLK_DIV cycles SCK high, then CLK_DIV cycles SCK low)
  - Bits go out MSB-first within each byte; bytes go out in order: op, payload 0, 1, …
  - On the clock edge that raises SCK, sample SPI_DO into the receive shift register.
  - On the edge that lowers SCK, drive the next bit onto SPI_DI.
  - The low phase of the last bit is the hold time; SPI_DI stays at the last bit value during it.
- **GAP** (CLK_DIV cycles)
  - SS3=1, SCK=0, SPI_DI=0.
  - Leaving GAP: enter IDLE and pulse rsp_valid in the first IDLE cycle.
  - rsp_status and rsp_data are valid from that cycle and are held until the next accept.
- cmd_valid asserted while busy is ignored; there is no queueing.
- Bit and byte counters are sized for 72 bits. The divider counter reloads to CLK_DIV−1 on every phase change.
- RESET (any state, including mid-SHIFT) returns the block to IDLE values on the next edge:
  - rsp_valid=0, busy=0, rsp_status=0, rsp_data=0.
  - No partial rsp_valid is ever produced for an aborted transaction.
- cmd_len=0 is a legal opcode-only transaction of 8 bits.

## Timing
- Accept edge = T0.
- SS3 falls and DI carries op[7] in the cycle after T0. SETUP occupies cycles T0+1 … T0+CLK_DIV.
- Bit k rises SCK at cycle T0+1+CLK_DIV·(1+2k).
- SS3 rises at T0+1+CLK_DIV·(1+2N).
- rsp_valid is high in exactly cycle T0+1+CLK_DIV·(2+2N); cmd_ready is also 1 in that cycle.
- A back-to-back accept is possible in the rsp_valid cycle. Minimum SS3-high time is therefore CLK_DIV+1 cycles.
- Reset value of every output:
  - SPI_SS3=1
  - all other outputs 0, except cmd_ready=1.

## Test plan
- **Loopback:** CLK_DIV=2, SPI_DO tied to SPI_DI; op=0x1E, len=4, data=0x00000000_A55A3CC3.
  - Expect rsp_status=0x1E and rsp_data=0x00000000_A55A3CC3.
  - Expect rsp_valid exactly 165 cycles after accept, and SCK toggling 80 times.
- **Slave model:** a mode-0 SPI slave returns 0x5A on every byte; CLK_DIV=1, op=0x01, len=2.
  - Expect rsp_status=0x5A and rsp_data=0x0000_0000_0000_5A5A.
  - The slave decodes op=0x01 and payload bytes 0x34, 0x12 from cmd_data=0x1234.
- **Opcode-only and saturation:**
  - len=0 → exactly 8 SCK rising edges; rsp_data=0.
  - len=15 → exactly 72 rising edges, as for len=8.
- **Busy-ignore and back-to-back:**
  - Hold cmd_valid continuously with two different ops.
  - cmd_ready is 0 throughout the first transaction.
  - The second op is accepted in the rsp_valid cycle; SS3 is high for exactly CLK_DIV+1 cycles between them.
- **Reset mid-SHIFT:** assert RESET for 1 cycle after bit 13 of a len=3 command.
  - Next cycle: SS3=1, SCK=0, busy=0, cmd_ready=1.
  - No rsp_valid appears in the following 200 cycles.
- **Mode-0 timing check:** an assertion monitor verifies:
  - SPI_DI never changes on a cycle where SCK rises or is high.
  - SS3 is never low while in IDLE.
